// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between fetch (I) and load/store (D).
// D has priority; I is forced to win after MAX_WAIT consecutive losses.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic [1:0]        i_size_i,
  output logic              i_gnt_o,
  output logic              i_done_o,
  output logic              i_err_o,
  output logic [DATA_W-1:0] i_rd_data_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [1:0]        d_size_i,
  input  logic [DATA_W-1:0] d_wr_data_i,
  output logic              d_gnt_o,
  output logic              d_done_o,
  output logic              d_err_o,
  output logic [DATA_W-1:0] d_rd_data_o,
  output logic              mem_rd_enable_o,
  output logic              mem_wr_enable_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [1:0]        mem_size_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  input  logic              mem_busy_i,
  output logic              owner_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_WAIT);

  state_t r_state;
  state_t w_next;

  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [CW-1:0]     r_starve;

  logic w_any;
  logic w_d_wins;
  logic w_aligned;
  logic w_start;

  assign w_any    = i_req_i | d_req_i;
  assign w_d_wins = d_req_i & (~i_req_i | (r_starve != STARVE_MAX));
  assign w_start  = (r_state == S_IDLE) & w_any;

  // Alignment of the latched access
  always_comb begin
    w_aligned = 1'b1;
    unique case (1'b1)
      (r_size == SZ_HALF): w_aligned = ~r_addr[0];
      (r_size == SZ_WORD): w_aligned = (r_addr[1:0] == 2'b00);
      default:             w_aligned = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Latch winner's access and track I starvation
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_owner  <= 1'b0;
      r_addr   <= '0;
      r_size   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_starve <= '0;
    end else if (w_start) begin
      r_owner <= w_d_wins;
      r_addr  <= w_d_wins ? d_addr_i : i_addr_i;
      r_size  <= w_d_wins ? d_size_i : i_size_i;
      r_we    <= w_d_wins & d_we_i;
      r_wdata <= w_d_wins ? d_wr_data_i : '0;
      if (!w_d_wins)
        r_starve <= '0;
      else if (i_req_i && r_starve != STARVE_MAX)
        r_starve <= r_starve + 1'b1;
    end
  end

  // Next state and per-state outputs
  always_comb begin
    w_next          = r_state;
    i_gnt_o         = 1'b0;
    i_done_o        = 1'b0;
    i_err_o         = 1'b0;
    d_gnt_o         = 1'b0;
    d_done_o        = 1'b0;
    d_err_o         = 1'b0;
    i_rd_data_o     = '0;
    d_rd_data_o     = '0;
    mem_rd_enable_o = 1'b0;
    mem_wr_enable_o = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        i_gnt_o = ~r_owner;
        d_gnt_o = r_owner;
        if (w_aligned) begin
          mem_rd_enable_o = ~r_we;
          mem_wr_enable_o = r_we;
          w_next          = S_WAIT;
        end else begin
          i_done_o = ~r_owner;
          i_err_o  = ~r_owner;
          d_done_o = r_owner;
          d_err_o  = r_owner;
          w_next   = S_IDLE;
        end
      end
      S_WAIT: begin
        i_rd_data_o = mem_rd_data_i;
        d_rd_data_o = mem_rd_data_i;
        if (!mem_busy_i) begin
          i_done_o = ~r_owner;
          d_done_o = r_owner;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign mem_addr_o    = r_addr;
  assign mem_size_o    = r_size;
  assign mem_wr_data_o = r_wdata;
  assign owner_o       = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Linear steps with immediate assertions at each check point.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [1:0]  i_size;
  logic        i_gnt, i_done, i_err;
  logic [31:0] i_rd;
  logic        d_req, d_we;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic [31:0] d_wd;
  logic        d_gnt, d_done, d_err;
  logic [31:0] d_rd;
  logic        m_rd, m_wr;
  logic [31:0] m_addr;
  logic [1:0]  m_size;
  logic [31:0] m_wd;
  logic [31:0] m_rdata;
  logic        m_busy;
  logic        owner;

  int total = 0;
  int passed = 0;
  int failed = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_size_i(i_size),
    .i_gnt_o(i_gnt), .i_done_o(i_done), .i_err_o(i_err),
    .i_rd_data_o(i_rd),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr),
    .d_size_i(d_size), .d_wr_data_i(d_wd),
    .d_gnt_o(d_gnt), .d_done_o(d_done), .d_err_o(d_err),
    .d_rd_data_o(d_rd),
    .mem_rd_enable_o(m_rd), .mem_wr_enable_o(m_wr),
    .mem_addr_o(m_addr), .mem_size_o(m_size),
    .mem_wr_data_o(m_wd), .mem_rd_data_i(m_rdata),
    .mem_busy_i(m_busy), .owner_o(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a grant and check which side got it
  task automatic expect_grant(input logic exp_d, input string tag);
    int t;
    t = 0;
    while (!(i_gnt || d_gnt) && t < 8) begin
      step();
      t++;
    end
    chk({tag, "_seen"}, 32'(i_gnt | d_gnt), 32'd1);
    chk({tag, "_who"}, 32'(d_gnt), 32'(exp_d));
    step();
  endtask

  initial begin
    int pulses;
    rst_n   = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    i_size  = 2'd0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_size  = 2'd0;
    d_wd    = '0;
    m_rdata = '0;
    m_busy  = 1'b0;
    #12;
    chk("rst_gnt", {i_gnt, d_gnt}, 0);
    chk("rst_done", {i_done, d_done, i_err, d_err}, 0);
    chk("rst_en", {m_rd, m_wr}, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_owner", owner, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // I word read, no wait states
    i_req   = 1'b1;
    i_addr  = 32'h100;
    i_size  = 2'd2;
    m_rdata = 32'hCAFEF00D;
    step();
    chk("t1_gnt", i_gnt, 1);
    chk("t1_rden", {m_rd, m_wr}, 32'b10);
    chk("t1_addr", m_addr, 32'h100);
    chk("t1_idone_issue", i_done, 0);
    step();
    chk("t1_done", i_done, 1);
    chk("t1_err", i_err, 0);
    chk("t1_rdata", i_rd, 32'hCAFEF00D);
    chk("t1_en_wait", {m_rd, m_wr}, 0);
    i_req = 1'b0;
    step();
    chk("t1_idle", {i_done, i_gnt}, 0);

    // D half store with three busy cycles
    d_req  = 1'b1;
    d_we   = 1'b1;
    d_addr = 32'h204;
    d_size = 2'd1;
    d_wd   = 32'hBEEF;
    step();
    chk("t2_gnt", d_gnt, 1);
    chk("t2_wren", {m_rd, m_wr}, 32'b01);
    chk("t2_wdata", m_wd, 32'hBEEF);
    chk("t2_size", m_size, 1);
    chk("t2_owner", owner, 1);
    m_busy = 1'b1;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      pulses += int'(d_done) + int'(m_wr);
    end
    chk("t2_busy_quiet", pulses, 0);
    m_busy = 1'b0;
    #1;
    chk("t2_done", d_done, 1);
    d_req = 1'b0;
    d_we  = 1'b0;
    step();
    chk("t2_idle", d_done, 0);

    // Both requesting continuously: starvation bound
    i_req  = 1'b1;
    i_addr = 32'h40;
    i_size = 2'd2;
    d_req  = 1'b1;
    d_addr = 32'h80;
    d_size = 2'd2;
    expect_grant(1'b1, "s0");
    expect_grant(1'b1, "s1");
    expect_grant(1'b1, "s2");
    expect_grant(1'b1, "s3");
    expect_grant(1'b0, "s4");
    expect_grant(1'b1, "s5");
    expect_grant(1'b1, "s6");
    expect_grant(1'b1, "s7");
    expect_grant(1'b1, "s8");
    expect_grant(1'b0, "s9");
    i_req = 1'b0;
    d_req = 1'b0;
    step();
    step();

    // Misaligned I word read
    i_req  = 1'b1;
    i_addr = 32'h102;
    i_size = 2'd2;
    step();
    chk("t4_gnt", i_gnt, 1);
    chk("t4_done", i_done, 1);
    chk("t4_err", i_err, 1);
    chk("t4_en", {m_rd, m_wr}, 0);
    i_req = 1'b0;
    step();
    chk("t4_idle", {i_gnt, i_done, i_err}, 0);

    // Reset during WAIT
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h300;
    d_size  = 2'd2;
    m_rdata = 32'h12345678;
    m_busy  = 1'b1;
    step();
    step();
    chk("t5_wait", d_done, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_out", {d_gnt, d_done, m_rd, m_wr}, 0);
    chk("t5_rst_owner", owner, 0);
    chk("t5_rst_addr", m_addr, 0);
    #1 rst_n = 1'b1;
    step();
    chk("t5_regnt", d_gnt, 1);
    chk("t5_readdr", m_addr, 32'h300);
    m_busy = 1'b0;
    step();
    chk("t5_done", d_done, 1);
    chk("t5_rdata", d_rd, 32'h12345678);
    d_req = 1'b0;
    step();

    // D drops req in ISSUE: access completes, one done
    d_req  = 1'b1;
    d_addr = 32'h400;
    step();
    chk("t6_gnt", d_gnt, 1);
    d_req = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      pulses += int'(d_done);
    end
    chk("t6_pulses", pulses, 1);

    // Starve count untouched by solo D: I still wins 5th
    i_req  = 1'b1;
    i_addr = 32'h40;
    d_req  = 1'b1;
    d_addr = 32'h80;
    expect_grant(1'b1, "u0");
    expect_grant(1'b1, "u1");
    expect_grant(1'b1, "u2");
    expect_grant(1'b1, "u3");
    expect_grant(1'b0, "u4");
    i_req = 1'b0;
    d_req = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
